// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Covers state encodings, response payload, default build parameters and the address-check helper.
package imem_responder_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned DEF_MEM_AW  = 10;
    localparam int unsigned DEF_LATENCY = 2;

    // Reference NOP encoding; error responses return zero, not this word
    localparam logic [DATA_W-1:0] NOP_WORD = 16'h0800;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_t;

    // Misaligned PC or any byte-address bit above the storage window set
    function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned mem_aw);
        logic [ADDR_W-1:0] hi;
        hi = addr >> (mem_aw + 1);
        return addr[0] | (hi != '0);
    endfunction

endpackage

// File: rtl/imem_responder_array.sv
// Instruction storage: one synchronous write port for preloading and one asynchronous read port.
// Contents are deliberately not reset so a preloaded image survives a responder reset.
module imem_responder_array #(
    parameter int unsigned MEM_AW = 10,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [MEM_AW-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [MEM_AW-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_c_o
);

    localparam int unsigned DEPTH = 2 ** MEM_AW;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read sees pre-edge contents, so a same-cycle write is not forwarded
    assign rd_data_c_o = mem_q[rd_addr_i];

endmodule

// File: rtl/imem_responder.sv
// Fetch-side memory responder: one request in flight, fixed latency, valid/ready response.
// Supports redirect flush and a side load port that writes storage independently of the FSM.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned MEM_AW  = DEF_MEM_AW,
    parameter int unsigned LATENCY = DEF_LATENCY
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_flush_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              rsp_err_o,
    input  logic              ld_en_i,
    input  logic [MEM_AW-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i
);

    localparam logic [CNT_W-1:0] WAIT_INIT   = CNT_W'((LATENCY >= 2) ? LATENCY - 2 : 0);
    localparam logic             DIRECT_RESP = (LATENCY == 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    rsp_t              rsp_q, rsp_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rd_data;
    logic              accept_c;
    logic              req_err_c;

    imem_responder_array #(
        .MEM_AW (MEM_AW),
        .DATA_W (DATA_W)
    ) u_array (
        .clk_i       (clk_i),
        .wr_en_i     (ld_en_i),
        .wr_addr_i   (ld_addr_i),
        .wr_data_i   (ld_data_i),
        .rd_addr_i   (req_addr_i[MEM_AW:1]),
        .rd_data_c_o (rd_data)
    );

    // Ready depends only on registered state and flush, never on rsp_ready
    assign req_ready_o = (state_q == ST_IDLE) & ~req_flush_i;
    assign accept_c    = req_valid_i & req_ready_o;
    assign req_err_c   = addr_err(req_addr_i, MEM_AW);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rsp_d   = rsp_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    rsp_d.err  = req_err_c;
                    rsp_d.data = req_err_c ? '0 : rd_data;
                    if (DIRECT_RESP) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (req_flush_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (req_flush_i || rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_q.data;
    assign rsp_err_o   = rsp_q.err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a LATENCY=2 instance (u_l2) and a LATENCY=1 instance (u_l1)
// share all inputs; each scenario task checks the instance it targets.
module tb_imem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        req_flush;
    logic        rsp_ready;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [15:0] ld_data;

    logic        l2_req_ready, l2_rsp_valid, l2_rsp_err;
    logic [15:0] l2_rsp_data;
    logic        l1_req_ready, l1_rsp_valid, l1_rsp_err;
    logic [15:0] l1_rsp_data;

    int total = 0;
    int bad   = 0;

    imem_responder #(.MEM_AW(10), .LATENCY(2)) u_l2 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (l2_req_ready),
        .req_addr_i  (req_addr),
        .req_flush_i (req_flush),
        .rsp_valid_o (l2_rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (l2_rsp_data),
        .rsp_err_o   (l2_rsp_err),
        .ld_en_i     (ld_en),
        .ld_addr_i   (ld_addr),
        .ld_data_i   (ld_data)
    );

    imem_responder #(.MEM_AW(10), .LATENCY(1)) u_l1 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (l1_req_ready),
        .req_addr_i  (req_addr),
        .req_flush_i (req_flush),
        .rsp_valid_o (l1_rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (l1_rsp_data),
        .rsp_err_o   (l1_rsp_err),
        .ld_en_i     (ld_en),
        .ld_addr_i   (ld_addr),
        .ld_data_i   (ld_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled away from the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic load(input logic [9:0] a, input logic [15:0] d);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        step();
        ld_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++; if (l2_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", l2_rsp_valid); end
        total++; if (l2_rsp_data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", l2_rsp_data); end
        total++; if (l2_rsp_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", l2_rsp_err); end
        total++; if (l2_req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", l2_req_ready); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        load(10'h002, 16'hA5A5);
        req_valid = 1'b1; req_addr = 16'h0004; rsp_ready = 1'b1;
        settle();
        total++; if (l2_req_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_idle got=%b exp=1", l2_req_ready); end
        step();
        req_valid = 1'b0;
        settle();
        total++; if (l2_rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_c1 got=%b exp=0", l2_rsp_valid); end
        total++; if (l2_req_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_wait got=%b exp=0", l2_req_ready); end
        step();
        total++; if (l2_rsp_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_c2 got=%b exp=1", l2_rsp_valid); end
        total++; if (l2_rsp_data !== 16'hA5A5) begin bad++; $display("FAIL basic_data got=%h exp=a5a5", l2_rsp_data); end
        total++; if (l2_rsp_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", l2_rsp_err); end
        total++; if (l2_req_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_resp got=%b exp=0", l2_req_ready); end
        step();
        total++; if (l2_rsp_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_done got=%b exp=0", l2_rsp_valid); end
        total++; if (l2_req_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_done got=%b exp=1", l2_req_ready); end
    endtask

    task automatic test_backpressure();
        load(10'h003, 16'h1234);
        req_valid = 1'b1; req_addr = 16'h0006; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            total++; if (l2_rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, l2_rsp_valid); end
            total++; if (l2_rsp_data !== 16'h1234) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=1234", i, l2_rsp_data); end
            step();
        end
        rsp_ready = 1'b1;
        settle();
        total++; if (l2_rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_release got=%b exp=1", l2_rsp_valid); end
        step();
        total++; if (l2_rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_valid_after got=%b exp=0", l2_rsp_valid); end
        total++; if (l2_req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after got=%b exp=1", l2_req_ready); end
    endtask

    task automatic test_errors();
        logic [15:0] addrs [3];
        logic        exp_err [3];
        addrs[0] = 16'h0003; exp_err[0] = 1'b1;
        addrs[1] = 16'h0800; exp_err[1] = 1'b1;
        addrs[2] = 16'h0006; exp_err[2] = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_addr = addrs[i];
            step();
            req_valid = 1'b0;
            settle();
            total++; if (l2_rsp_valid !== 1'b0) begin bad++; $display("FAIL err_early_valid[%0d] got=%b exp=0", i, l2_rsp_valid); end
            step();
            total++; if (l2_rsp_valid !== 1'b1) begin bad++; $display("FAIL err_valid[%0d] got=%b exp=1", i, l2_rsp_valid); end
            total++; if (l2_rsp_err !== exp_err[i]) begin bad++; $display("FAIL err_flag[%0d] got=%b exp=%b", i, l2_rsp_err, exp_err[i]); end
            total++; if (l2_rsp_data !== (exp_err[i] ? 16'h0000 : 16'h1234)) begin bad++; $display("FAIL err_data[%0d] got=%h", i, l2_rsp_data); end
            step();
        end
    endtask

    task automatic test_flush();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 16'h0004;
        step();
        req_valid = 1'b0; req_flush = 1'b1;
        step();
        req_flush = 1'b0;
        settle();
        total++; if (l2_rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_wait_valid got=%b exp=0", l2_rsp_valid); end
        total++; if (l2_req_ready !== 1'b1) begin bad++; $display("FAIL flush_wait_ready got=%b exp=1", l2_req_ready); end
        step();
        total++; if (l2_rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_wait_later got=%b exp=0", l2_rsp_valid); end

        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 16'h0004;
        step();
        req_valid = 1'b0;
        step();
        total++; if (l2_rsp_valid !== 1'b1) begin bad++; $display("FAIL flush_resp_pre got=%b exp=1", l2_rsp_valid); end
        req_flush = 1'b1;
        step();
        req_flush = 1'b0;
        settle();
        total++; if (l2_rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_resp_valid got=%b exp=0", l2_rsp_valid); end
        total++; if (l2_req_ready !== 1'b1) begin bad++; $display("FAIL flush_resp_ready got=%b exp=1", l2_req_ready); end

        req_valid = 1'b1; req_flush = 1'b1; req_addr = 16'h0006;
        settle();
        total++; if (l2_req_ready !== 1'b0) begin bad++; $display("FAIL flush_idle_ready got=%b exp=0", l2_req_ready); end
        step();
        req_valid = 1'b0; req_flush = 1'b0;
        settle();
        total++; if (l2_req_ready !== 1'b1) begin bad++; $display("FAIL flush_idle_noaccept got=%b exp=1", l2_req_ready); end

        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 16'h0006;
        step();
        req_valid = 1'b0;
        settle();
        total++; if (l2_rsp_valid !== 1'b0) begin bad++; $display("FAIL flush_next_c1 got=%b exp=0", l2_rsp_valid); end
        step();
        total++; if (l2_rsp_valid !== 1'b1) begin bad++; $display("FAIL flush_next_valid got=%b exp=1", l2_rsp_valid); end
        total++; if (l2_rsp_data !== 16'h1234) begin bad++; $display("FAIL flush_next_data got=%h exp=1234", l2_rsp_data); end
        step();
    endtask

    task automatic test_async_reset();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 16'h0004;
        step();
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (l2_rsp_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", l2_rsp_valid); end
        total++; if (l2_rsp_data !== 16'h0000) begin bad++; $display("FAIL arst_data got=%h exp=0000", l2_rsp_data); end
        #1 rst_n = 1'b1;
        #1;
        total++; if (l2_req_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b exp=1", l2_req_ready); end
        step();
        total++; if (l2_rsp_valid !== 1'b0) begin bad++; $display("FAIL arst_stay_idle got=%b exp=0", l2_rsp_valid); end
        req_valid = 1'b1; req_addr = 16'h0004;
        step();
        req_valid = 1'b0;
        step();
        total++; if (l2_rsp_valid !== 1'b1) begin bad++; $display("FAIL arst_reread_valid got=%b exp=1", l2_rsp_valid); end
        total++; if (l2_rsp_data !== 16'hA5A5) begin bad++; $display("FAIL arst_reread_data got=%h exp=a5a5", l2_rsp_data); end
        step();
        step();
    endtask

    task automatic test_latency1_rbw();
        load(10'h005, 16'h1111);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 16'h000A;
        ld_en = 1'b1; ld_addr = 10'h005; ld_data = 16'h2222;
        settle();
        total++; if (l1_req_ready !== 1'b1) begin bad++; $display("FAIL l1_ready got=%b exp=1", l1_req_ready); end
        step();
        req_valid = 1'b0; ld_en = 1'b0;
        settle();
        total++; if (l1_rsp_valid !== 1'b1) begin bad++; $display("FAIL l1_valid got=%b exp=1", l1_rsp_valid); end
        total++; if (l1_rsp_data !== 16'h1111) begin bad++; $display("FAIL l1_old_data got=%h exp=1111", l1_rsp_data); end
        step();
        total++; if (l1_rsp_valid !== 1'b0) begin bad++; $display("FAIL l1_done got=%b exp=0", l1_rsp_valid); end
        req_valid = 1'b1; req_addr = 16'h000A;
        step();
        req_valid = 1'b0;
        settle();
        total++; if (l1_rsp_valid !== 1'b1) begin bad++; $display("FAIL l1_valid2 got=%b exp=1", l1_rsp_valid); end
        total++; if (l1_rsp_data !== 16'h2222) begin bad++; $display("FAIL l1_new_data got=%h exp=2222", l1_rsp_data); end
        total++; if (l1_rsp_err !== 1'b0) begin bad++; $display("FAIL l1_err got=%b exp=0", l1_rsp_err); end
        step();
        step();
    endtask

    initial begin
        req_valid = 1'b0;
        req_addr  = 16'h0000;
        req_flush = 1'b0;
        rsp_ready = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = 10'h000;
        ld_data   = 16'h0000;
        test_reset();
        test_basic();
        test_backpressure();
        test_errors();
        test_flush();
        test_async_reset();
        test_latency1_rbw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
